// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM states and master indices.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic [1:0] onehot(input logic idx);
        return (idx == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin winner choice between two masters, with optional bus locking.
// Lock hold-over is compiled in only when BUS_ARBITER_LOCK_EN is defined.
module rr_select
    import bus_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       update,
    input  logic       owner,
    output logic       winner
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX);

    logic last_q;

`ifdef BUS_ARBITER_LOCK_EN
    logic            lock_q;
    logic [CntW-1:0] cnt_q;
`else
    logic unused_lock;
    assign unused_lock = ^{lock, CntMax};
`endif

    always_comb begin
        if (req[M0] && req[M1]) begin
            winner = ~last_q;
        end else begin
            winner = req[M1] ? M1 : M0;
        end
`ifdef BUS_ARBITER_LOCK_EN
        // A locked owner keeps the bus until its streak of grants reaches LOCK_MAX.
        if (lock_q && req[last_q] && (cnt_q < CntMax)) begin
            winner = last_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= M1;
`ifdef BUS_ARBITER_LOCK_EN
            lock_q <= 1'b0;
            cnt_q  <= '0;
`endif
        end else if (update) begin
            last_q <= owner;
`ifdef BUS_ARBITER_LOCK_EN
            lock_q <= lock[owner];
            cnt_q  <= ((owner == last_q) && (cnt_q < CntMax)) ? cnt_q + CntW'(1) : CntW'(1);
`endif
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, single-slave bus arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Define BUS_ARBITER_LOCK_EN to let a master hold the bus via its lock input.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m0_lock,
    input  logic              m1_lock,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        grant
);

    state_t            state_q;
    logic              sel_q;
    logic              we_q;
    logic [1:0]        grant_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              winner;
    logic              win_we;
    logic              update;
    logic [1:0]        req;
    logic [1:0]        lock;

    assign req    = {m1_req, m0_req};
    assign lock   = {m1_lock, m0_lock};
    assign win_we = (winner == M1) ? m1_we : m0_we;

    // The enabled RESP cycle is the single point where an access completes.
    assign update = en && !rst && (state_q == RESP);

    rr_select #(
        .LOCK_MAX (LOCK_MAX)
    ) u_rr_select (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .update (update),
        .owner  (sel_q),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= M0;
            we_q     <= 1'b0;
            grant_q  <= 2'b00;
            s_read   <= 1'b0;
            s_write  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q   <= winner;
                        we_q    <= win_we;
                        s_addr  <= (winner == M1) ? m1_addr : m0_addr;
                        s_wdata <= (winner == M1) ? m1_wdata : m0_wdata;
                        grant_q <= onehot(winner);
                        s_read  <= !win_we;
                        s_write <= win_we;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    s_read  <= 1'b0;
                    s_write <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    if (!we_q) begin
                        if (sel_q == M1) begin
                            rdata1_q <= s_rdata;
                        end else begin
                            rdata0_q <= s_rdata;
                        end
                    end
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_ack = update && (sel_q == M0);
    assign m1_ack = update && (sel_q == M1);

    // Read data is forwarded during the ack cycle and held in the register afterwards.
    assign m0_rdata = (m0_ack && !we_q) ? s_rdata : rdata0_q;
    assign m1_rdata = (m1_ack && !we_q) ? s_rdata : rdata1_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_bus_arbiter;

    localparam int LM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [31:0] s_rdata = '0;
    logic        m0_ack, m1_ack, s_read, s_write;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [1:0]  grant;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int left0 = 0, left1 = 0;
    bit seen0 = 0, seen1 = 0;
    int log_m[$];
    int log_c[$];
    int strobe_cnt = 0;
    int exp_seq[5];
    int t0;

    bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LOCK_MAX (LM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_we    (m0_we),
        .m1_we    (m1_we),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_wdata (m0_wdata),
        .m1_wdata (m1_wdata),
        .m0_lock  (m0_lock),
        .m1_lock  (m1_lock),
        .m0_ack   (m0_ack),
        .m1_ack   (m1_ack),
        .m0_rdata (m0_rdata),
        .m1_rdata (m1_rdata),
        .s_read   (s_read),
        .s_write  (s_write),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .grant    (grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] slave_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hCAFEBABE : (32'hD000_0000 | a);
    endfunction

    // Slave: read data appears the cycle after the read strobe.
    always @(posedge clk) if (s_read) s_rdata <= slave_val(s_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction model: stage counts enabled cycles since the grant (0 = bus free).
    int          stg = 0;
    int          own = 0;
    int          last = 1;
    bit          t_we = 0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    logic [31:0] held[2];
`ifdef BUS_ARBITER_LOCK_EN
    bit lk = 0;
    int streak = 0;
`endif

    function automatic int pick();
`ifdef BUS_ARBITER_LOCK_EN
        if (lk && ((last == 0) ? m0_req : m1_req) && streak < LM) return last;
`endif
        if (m0_req && m1_req) return 1 - last;
        return m1_req ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            stg = 0; own = 0; last = 1; t_we = 0; t_addr = '0; t_wdata = '0;
            held[0] = '0; held[1] = '0;
`ifdef BUS_ARBITER_LOCK_EN
            lk = 0; streak = 0;
`endif
        end else if (en) begin
            if (stg == 0) begin
                if (m0_req || m1_req) begin
                    own     = pick();
                    t_we    = (own == 1) ? m1_we : m0_we;
                    t_addr  = (own == 1) ? m1_addr : m0_addr;
                    t_wdata = (own == 1) ? m1_wdata : m0_wdata;
                    stg     = 1;
                end
            end else if (stg == 1) begin
                stg = 2;
            end else begin
                if (!t_we) held[own] = s_rdata;
`ifdef BUS_ARBITER_LOCK_EN
                lk     = (own == 1) ? m1_lock : m0_lock;
                streak = (own == last && streak < LM) ? streak + 1 : 1;
`endif
                last = own;
                stg  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic [1:0]  eg;
            logic        ea0, ea1;
            logic [31:0] erd0, erd1;
            eg   = (stg == 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
            ea0  = (stg == 2) && (own == 0) && en && !rst;
            ea1  = (stg == 2) && (own == 1) && en && !rst;
            erd0 = (ea0 && !t_we) ? s_rdata : held[0];
            erd1 = (ea1 && !t_we) ? s_rdata : held[1];
            chk("grant", grant, eg);
            chk("s_read", s_read, (stg == 1) && !t_we);
            chk("s_write", s_write, (stg == 1) && t_we);
            chk("s_addr", s_addr, t_addr);
            chk("s_wdata", s_wdata, t_wdata);
            chk("m0_ack", m0_ack, ea0);
            chk("m1_ack", m1_ack, ea1);
            chk("m0_rdata", m0_rdata, erd0);
            chk("m1_rdata", m1_rdata, erd1);
            seen0 = m0_ack;
            seen1 = m1_ack;
            if (m0_ack) begin log_m.push_back(0); log_c.push_back(cyc); end
            if (m1_ack) begin log_m.push_back(1); log_c.push_back(cyc); end
            if (s_read) strobe_cnt++;
        end
    end

    // Masters hold req until their remaining access count reaches zero.
    always @(posedge clk) begin
        #2;
        if (seen0 && left0 > 0) left0--;
        if (seen1 && left1 > 0) left1--;
        m0_req = (left0 > 0);
        m1_req = (left1 > 0);
    end

    task automatic issue(input int m, input int n, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit lock_in);
        if (m == 0) begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lock_in; left0 = n;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lock_in; left1 = n;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (left0 == 0 && left1 == 0 && stg == 0) done = 1;
        end
        chk("wait_idle", done, 1'b1);
    endtask

    task automatic clear_log();
        log_m.delete();
        log_c.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_strobes", {s_read, s_write}, 2'b00);
        chk("reset_rdata0", m0_rdata, 32'h0);

        // Single m0 read: strobe in cycle 2, ack with data in cycle 3.
        @(posedge clk); #1 issue(0, 1, 1'b0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rd_s_read", s_read, 1'b1);
        chk("rd_s_addr", s_addr, 32'h10);
        chk("rd_grant", grant, 2'b01);
        @(negedge clk);
        chk("rd_ack", m0_ack, 1'b1);
        chk("rd_rdata", m0_rdata, 32'hCAFEBABE);
        wait_idle();

        // m1 read, then m1 write which must leave m1_rdata alone.
        @(posedge clk); #1 issue(1, 1, 1'b0, 32'h30, 32'h0, 1'b0);
        wait_idle();
        chk("m1_read", m1_rdata, 32'hD000_0030);
        @(posedge clk); #1 issue(1, 1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("wr_s_write", {s_read, s_write}, 2'b01);
        chk("wr_s_addr", s_addr, 32'h20);
        chk("wr_s_wdata", s_wdata, 32'h1234_5678);
        @(negedge clk);
        chk("wr_ack", m1_ack, 1'b1);
        chk("wr_rdata_kept", m1_rdata, 32'hD000_0030);
        wait_idle();

        // Continuous contention: strict alternation, acks 3 cycles apart.
        clear_log();
        @(posedge clk); #1;
        issue(0, 4, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1, 4, 1'b0, 32'h44, 32'h0, 1'b0);
        wait_idle();
        chk("rr_count", log_m.size(), 8);
        for (int i = 0; i < log_m.size(); i++) chk("rr_order", log_m[i], i % 2);
        for (int i = 1; i < log_c.size(); i++) chk("rr_spacing", log_c[i] - log_c[i-1], 3);

        // en low for 5 cycles during ACCESS: ack exactly 5 cycles late, once.
        clear_log();
        strobe_cnt = 0;
        @(posedge clk); #1 issue(0, 1, 1'b0, 32'h50, 32'h0, 1'b0);
        t0 = cyc;
        @(posedge clk); #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        wait_idle();
        chk("stall_ack_count", log_m.size(), 1);
        if (log_c.size() > 0) chk("stall_ack_delay", log_c[0] - t0, 7);
        chk("stall_strobe_len", strobe_cnt, 6);
        chk("stall_rdata", m0_rdata, 32'hD000_0050);

        // Reset during RESP: no ack, outputs cleared, next tie goes to m0.
        clear_log();
        @(posedge clk); #1 issue(1, 1, 1'b0, 32'h60, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1; left1 = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_no_ack", log_m.size(), 0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        @(posedge clk); #1;
        issue(0, 1, 1'b0, 32'h70, 32'h0, 1'b0);
        issue(1, 1, 1'b0, 32'h74, 32'h0, 1'b0);
        wait_idle();
        chk("rst_tie_count", log_m.size(), 2);
        if (log_m.size() > 0) chk("rst_tie_winner", log_m[0], 0);

        // m0 requests with lock while m1 also requests.
`ifdef BUS_ARBITER_LOCK_EN
        exp_seq = '{0, 0, 0, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0};
`endif
        clear_log();
        @(posedge clk); #1;
        issue(0, 6, 1'b0, 32'h80, 32'h0, 1'b1);
        issue(1, 3, 1'b0, 32'h84, 32'h0, 1'b0);
        wait_idle();
        m0_lock = 1'b0;
        chk("lock_count", log_m.size(), 9);
        for (int i = 0; i < 5 && i < log_m.size(); i++) chk("lock_order", log_m[i], exp_seq[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, slave/master address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter LOCK_MAX, default 4, maximum consecutive locked grants to one master.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  global enable; when low, all state holds.
- m0_req, m1_req  in  1  master access request; held until ack.
- m0_we, m1_we  in  1  1=write, 0=read.
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_lock, m1_lock  in  1  request to keep the bus after this access.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  DATA_W  read data, valid with ack, held until next ack to that master.
- s_read, s_write  out  1  slave read/write strobe.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_rdata  in  DATA_W  slave read data, valid one cycle after the s_read strobe.
- grant  out  2  one-hot current owner; 00 when idle.

Function
REQ-005 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; every state lasts exactly one enabled cycle.
REQ-006 IDLE: if any req, SHALL select a winner, register its we/addr/wdata into s_* regs, set grant, and go to ACCESS; otherwise stay in IDLE with grant=00.
REQ-007 Winner selection SHALL be round-robin: on simultaneous requests, the master not granted last wins; a single requester always wins.
REQ-008 ACCESS: SHALL assert exactly one of s_read/s_write for one cycle with the registered s_addr/s_wdata.
REQ-009 RESP: SHALL deassert strobes, copy s_rdata into the winner's mX_rdata (reads only), pulse the winner's mX_ack for one cycle, update the last-granted pointer, and return to IDLE.
REQ-010 Latency SHALL be 3 cycles from req sampled in IDLE to ack; throughput one access per 3 cycles.
REQ-011 Write accesses SHALL leave mX_rdata unchanged.
REQ-012 A req deasserted before ack SHALL NOT abort an access already in ACCESS/RESP.
REQ-013 With en low, FSM, strobes and registers SHALL hold; any pending ack pulse SHALL be delayed, never lost or duplicated.
REQ-014 s_read and s_write SHALL never be asserted simultaneously; at most one mX_ack SHALL be high in any cycle.

Reset
REQ-015 On rst: state=IDLE; grant=00; s_read=s_write=0; s_addr=s_wdata=0; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; last-granted pointer=m1 (so m0 wins the first tie); lock counter=0.
REQ-016 rst asserted in ACCESS or RESP SHALL abandon the access with no ack; rst SHALL take priority over en.

Configuration
REQ-017 Macro BUS_ARBITER_LOCK_EN: when defined, if the winner's mX_lock is high in RESP and that master requests in the next IDLE, it SHALL win regardless of round-robin, for at most LOCK_MAX consecutive grants, after which normal round-robin applies and the counter clears; the counter SHALL also clear on any grant change.
REQ-018 Without BUS_ARBITER_LOCK_EN, the lock ports SHALL exist but be ignored; arbitration is pure round-robin.

Structure
REQ-019 A shared package bus_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and the master-index constants M0, M1.
REQ-020 The round-robin/lock winner logic SHALL be a sub-module rr_select (combinational choice plus pointer and lock counter registers); bus_arbiter instantiates it once.

Verification
REQ-021 Reset, then m0 read addr 0x10, slave returns 0xCAFEBABE -> s_read at cycle 2, m0_ack plus m0_rdata=0xCAFEBABE at cycle 3, grant=01 during the access.
REQ-022 m0 and m1 request together continuously -> grants alternate m0,m1,m0,m1; acks every 3 cycles; never two acks in one cycle.
REQ-023 m1 write addr 0x20 data 0x12345678 -> s_write=1 for one cycle with s_addr=0x20 and s_wdata=0x12345678; m1_rdata unchanged.
REQ-024 en low for 5 cycles while in ACCESS -> strobe held, ack arrives exactly 5 cycles late, only once.
REQ-025 rst asserted during RESP -> no ack; next cycle all outputs at reset values; the next tie is won by m0.
REQ-026 With BUS_ARBITER_LOCK_EN, LOCK_MAX=4, m0 requesting with lock=1 and m1 also requesting -> m0 granted 4 times consecutively, then m1; without the macro, strict alternation.
